// File: rtl/shift_piso_tx.sv
// shift_piso_tx: parallel-in/serial-out transmitter paced by a divider tick, with busy/done handshake.
// Defining SHIFT_PISO_PARITY_EN appends an even-parity bit after the data bits.
module shift_piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             s_out,
  output logic             busy,
  output logic             done
);
`ifdef SHIFT_PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [FRAME_LEN-1:0] sr, sr_nx, frame;
  logic [CW-1:0] cnt, cnt_nx;
  logic s_out_nx, busy_nx, done_nx, last;
  // The parity bit rides in the shift register so it leaves right after the data bits.
`ifdef SHIFT_PISO_PARITY_EN
  assign frame = MSB_FIRST ? {d, ^d} : {^d, d};
`else
  assign frame = d;
`endif
  assign last = cnt == CW'(FRAME_LEN - 1);
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    s_out_nx = s_out;
    busy_nx  = busy;
    done_nx  = 1'b0;
    case (state)
      IDLE: if (load) begin
        state_nx = SHIFT;
        busy_nx  = 1'b1;
        cnt_nx   = '0;
        s_out_nx = MSB_FIRST ? frame[FRAME_LEN-1] : frame[0];
        sr_nx    = MSB_FIRST ? frame << 1 : frame >> 1;
      end
      SHIFT: if (tick) begin
        cnt_nx   = cnt + 1'b1;
        sr_nx    = MSB_FIRST ? sr << 1 : sr >> 1;
        s_out_nx = last ? 1'b0 : (MSB_FIRST ? sr[FRAME_LEN-1] : sr[0]);
        state_nx = last ? DONE : SHIFT;
        busy_nx  = !last;
        done_nx  = last;
      end
      DONE: begin
        state_nx = IDLE;
        s_out_nx = 1'b0;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      s_out <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
      s_out <= s_out_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end
endmodule

// File: doc/shift_piso_tx.md
Name: shift_piso_tx

Overview:
- Parallel-in/serial-out transmitter. Loads a WIDTH-bit word and shifts it out one bit per divider tick on s_out.
- Serves as the sending end for the team's SIPO LED/shift-register chains.
- Sits after the clock-divider block: its 1-clk tick pulse paces the shift, while all logic runs on the fast clk.
- Provides a busy/done handshake so a controller can stream words back-to-back.

Parameters:
- WIDTH, 8, number of data bits per frame (2..32)
- MSB_FIRST, 0, 0 = shift LSB first, 1 = shift MSB first

Ports:
- clk  input  1  system clock; all flops on rising edge
- reset  input  1  asynchronous, active-low reset (reset = 0 clears all state immediately)
- tick  input  1  one-clk-wide shift strobe from the clock divider
- load  input  1  request to capture d and start a frame
- d  input  WIDTH  parallel data word
- s_out  output  1  serial data out
- busy  output  1  frame in progress
- done  output  1  one-clk pulse at end of frame

Behaviour:
- All outputs and state are registered. Only one clock domain is used.
- Reset values: s_out=0, busy=0, done=0, shift register=0, bit counter=0, state=IDLE.
- Reset asserted mid-frame aborts the frame; no done pulse is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 captures d. State goes to SHIFT and busy=1 from the next cycle.
  - On that same next cycle, s_out = first bit: d[0], or d[WIDTH-1] if MSB_FIRST.
  - A tick in IDLE has no effect.
  - load and tick in the same IDLE cycle: load is taken, tick is ignored.
- SHIFT:
  - Each tick advances s_out to the next bit (one-clk latency after the tick) and increments the bit counter.
  - Each bit is held for exactly one tick interval; the first bit lasts from load+1 to the first tick.
  - When the tick that ends the last bit arrives (counter = FRAME_LEN-1), state goes to DONE.
  - FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
  - Clk cycles without tick hold all state.
- DONE: lasts one clk. done=1, busy=0, s_out=0; then IDLE.
- load while busy=1 or in DONE is ignored. d is not re-sampled and the frame is not restarted.
- load asserted on the cycle after done (IDLE) starts a new frame.
  - Minimum gap between frames: one DONE cycle plus one load cycle.
- The bit counter is $clog2(FRAME_LEN+1) bits wide and never wraps within a frame. It is cleared on load.
- The shift register fills with 0 on each shift, so a stuck state can never output stale data.
- tick asserted on consecutive clks is legal; each cycle counts as one shift.

Optional Feature:
- Macro: SHIFT_PISO_PARITY_EN.
- Defined:
  - One extra bit is appended after the data bits: even parity, the XOR of all WIDTH bits of captured d.
  - FRAME_LEN = WIDTH+1, and done pulses one tick interval later.
- Undefined:
  - No parity logic is present. FRAME_LEN = WIDTH.

Test Plan:
- Reset then idle:
  - reset=0 for 3 clks, then 1; no load; ticks every 4 clks.
  - Required: s_out=0, busy=0, done=0 throughout.
- LSB-first frame (WIDTH=8, MSB_FIRST=0):
  - load d=8'hA5, ticks every 4 clks.
  - Required: s_out sequence 1,0,1,0,0,1,0,1; busy=1 for 8 tick intervals; done=1 for exactly one clk after the 8th tick; busy falls the same cycle.
- MSB-first frame:
  - MSB_FIRST=1, load d=8'hC3.
  - Required: s_out = 1,1,0,0,0,0,1,1, then done pulse.
- Load/tick collisions:
  - load d=8'hFF with tick in the same cycle, then load d=8'h00 mid-frame.
  - Required: first tick ignored; all 8 bits = 1; the second load has no effect; one done only.
- Reset mid-frame:
  - load d=8'h0F, drop reset after 3 ticks.
  - Required: s_out, busy and done go to 0 immediately; no done pulse.
  - After release, load d=8'h01 gives a clean frame 1,0,0,0,0,0,0,0.
- Parity (SHIFT_PISO_PARITY_EN defined):
  - load d=8'h07.
  - Required: 8 data bits 1,1,1,0,0,0,0,0, then parity bit 1; done after the 9th tick.
  - Repeat with d=8'h03: parity bit 0.
